// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle execute-stage ALU: op codes, FSM states
// and small op-classification helpers.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10,
        OP_MULH = 4'd11,
        OP_DIV  = 4'd12,
        OP_REM  = 4'd13,
        OP_DIVU = 4'd14,
        OP_REMU = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_iterative(alu_op_e op);
        return op >= OP_MUL;
    endfunction

    function automatic logic is_div(alu_op_e op);
        return op >= OP_DIV;
    endfunction

    function automatic logic is_signed_div(alu_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem(alu_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider sharing one 2*XLEN
// accumulator; done and result are combinational on the final iteration.
module ex_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] acc, acc_nx, prod;
    logic [XLEN-1:0]   opnd, mag_a, mag_b, pick;
    logic [CNT_W-1:0]  cnt;
    logic              busy, mul_q, hi_q, rem_q, neg_q;
    logic              sgn, sa, sb;
    logic [XLEN:0]     sum, rem_sh, diff;

    // Operands are reduced to magnitudes at start; the sign is reapplied at the end.
    always_comb begin
        sgn   = (op == OP_MULH) || is_signed_div(op);
        sa    = sgn & a[XLEN-1];
        sb    = sgn & b[XLEN-1];
        mag_a = sa ? -a : a;
        mag_b = sb ? -b : b;
    end

    always_comb begin
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff   = rem_sh - {1'b0, opnd};
        if (mul_q)
            acc_nx = {sum, acc[XLEN-1:1]};
        else if (!diff[XLEN])
            acc_nx = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_nx = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    always_comb begin
        prod = neg_q ? -acc_nx : acc_nx;
        pick = rem_q ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
        if (mul_q)
            result = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        else
            result = neg_q ? -pick : pick;
    end

    assign done = busy && (cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            opnd  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            mul_q <= 1'b0;
            hi_q  <= 1'b0;
            rem_q <= 1'b0;
            neg_q <= 1'b0;
        end else if (flush) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            mul_q <= !is_div(op);
            hi_q  <= (op == OP_MULH);
            rem_q <= is_rem(op);
            neg_q <= is_rem(op) ? sa : (sa ^ sb);
            acc   <= {{XLEN{1'b0}}, is_div(op) ? mag_a : mag_b};
            opnd  <= is_div(op) ? mag_b : mag_a;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            acc <= acc_nx;
            if (done) begin
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ex_seq_alu.sv
// Multi-cycle execute-stage ALU: single-cycle ops and divide special cases
// complete in one cycle, MUL/DIV families iterate in ex_muldiv_iter.
module ex_seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_flush_in,
    input  logic            ex_valid_in,
    output logic            ex_ready_out,
    input  logic [XLEN-1:0] ex_operand1_in,
    input  logic [XLEN-1:0] ex_operand2_in,
    input  logic [3:0]      ex_alu_op_in,
    output logic            ex_valid_out,
    input  logic            ex_ready_in,
    output logic [XLEN-1:0] ex_alu_result_out
);

    localparam int SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_e      state, state_nx;
    alu_op_e         op;
    logic [XLEN-1:0] a, b, fast_res, md_res;
    logic [SH_W-1:0] sh;
    logic            accept, special, iter_path, md_start, md_done;
    logic            ld_fast, ld_md;

    assign op = alu_op_e'(ex_alu_op_in);
    assign a  = ex_operand1_in;
    assign b  = ex_operand2_in;
    assign sh = b[SH_W-1:0];

    assign ex_ready_out = rst_n && ((state == ST_IDLE) || ((state == ST_DONE) && ex_ready_in));
    assign ex_valid_out = (state == ST_DONE);
    assign accept       = ex_valid_in && ex_ready_out;

    // Divide-by-zero and MIN/-1 overflow bypass the iterative datapath.
    assign special   = is_div(op) && ((b == '0) ||
                       (is_signed_div(op) && (a == MIN_VAL) && (b == '1)));
    assign iter_path = is_iterative(op) && !special;

    always_comb begin
        fast_res = '0;
        case (op)
            OP_ADD:  fast_res = a + b;
            OP_SUB:  fast_res = a - b;
            OP_AND:  fast_res = a & b;
            OP_OR:   fast_res = a | b;
            OP_XOR:  fast_res = a ^ b;
            OP_SLL:  fast_res = a << sh;
            OP_SRL:  fast_res = a >> sh;
            OP_SRA:  fast_res = $signed(a) >>> sh;
            OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, a < b};
            default: begin
                if (b == '0)
                    fast_res = is_rem(op) ? a : '1;
                else
                    fast_res = is_rem(op) ? '0 : MIN_VAL;
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        ld_fast  = 1'b0;
        ld_md    = 1'b0;
        md_start = 1'b0;
        if (ex_flush_in) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_BUSY: if (md_done) begin
                    state_nx = ST_DONE;
                    ld_md    = 1'b1;
                end
                ST_DONE: if (ex_ready_in) state_nx = ST_IDLE;
                default: ;
            endcase
            // Accept is only possible from IDLE or a draining DONE.
            if (accept) begin
                if (iter_path) begin
                    state_nx = ST_BUSY;
                    md_start = 1'b1;
                end else begin
                    state_nx = ST_DONE;
                    ld_fast  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_alu_result_out <= '0;
        else if (ld_fast)
            ex_alu_result_out <= fast_res;
        else if (ld_md)
            ex_alu_result_out <= md_res;
    end

    ex_muldiv_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (ex_flush_in),
        .start  (md_start),
        .op     (op),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_res)
    );

endmodule

// File: tb/tb_ex_seq_alu.sv
// Directed plus randomized checks of ex_seq_alu against an arithmetic reference model.
module tb_ex_seq_alu;

    localparam int XLEN = 64;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_flush_in = 1'b0;
    logic        ex_valid_in = 1'b0;
    logic        ex_ready_out;
    logic [63:0] ex_operand1_in = '0;
    logic [63:0] ex_operand2_in = '0;
    logic [3:0]  ex_alu_op_in = '0;
    logic        ex_valid_out;
    logic        ex_ready_in = 1'b1;
    logic [63:0] ex_alu_result_out;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    ex_seq_alu #(.XLEN(XLEN)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ex_flush_in       (ex_flush_in),
        .ex_valid_in       (ex_valid_in),
        .ex_ready_out      (ex_ready_out),
        .ex_operand1_in    (ex_operand1_in),
        .ex_operand2_in    (ex_operand2_in),
        .ex_alu_op_in      (ex_alu_op_in),
        .ex_valid_out      (ex_valid_out),
        .ex_ready_in       (ex_ready_in),
        .ex_alu_result_out (ex_alu_result_out)
    );

    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] ps;
        logic        [63:0]  r;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[5:0];
            4'd6:  r = a >> b[5:0];
            4'd7:  r = $signed(a) >>> b[5:0];
            4'd8:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd9:  r = (a < b) ? 64'd1 : 64'd0;
            4'd10: r = a * b;
            4'd11: begin
                ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                r  = ps[127:64];
            end
            4'd12: r = (b == 0) ? ONES : (a == MIN && b == ONES) ? MIN : 64'($signed(a) / $signed(b));
            4'd13: r = (b == 0) ? a : (a == MIN && b == ONES) ? 64'd0 : 64'($signed(a) % $signed(b));
            4'd14: r = (b == 0) ? ONES : a / b;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        if (op < 4'd10) return 1;
        if (op >= 4'd12 && b == 0) return 1;
        if ((op == 4'd12 || op == 4'd13) && a == MIN && b == ONES) return 1;
        return XLEN + 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction from IDLE: accept, scramble inputs, measure latency, check, drain.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        int lat;
        int w;
        w = 0;
        while (!ex_ready_out && w < 200) begin
            @(posedge clk); #1; w++;
        end
        ex_alu_op_in   = op;
        ex_operand1_in = a;
        ex_operand2_in = b;
        ex_valid_in    = 1'b1;
        ex_ready_in    = 1'b1;
        @(posedge clk); #1;
        ex_valid_in    = 1'b0;
        ex_operand1_in = {$urandom, $urandom};
        ex_operand2_in = {$urandom, $urandom};
        ex_alu_op_in   = 4'($urandom);
        lat = 1;
        while (!ex_valid_out && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat(op, a, b)));
        chk({tag, " result"}, ex_alu_result_out, ref_alu(op, a, b));
        @(posedge clk); #1;
        chk({tag, " drain"}, {63'd0, ex_valid_out}, 64'd0);
    endtask

    initial begin
        logic [63:0] ra, rb, held;
        logic [3:0]  rop;
        int          seen;

        // reset state
        #12;
        chk("rst valid", {63'd0, ex_valid_out}, 64'd0);
        chk("rst ready", {63'd0, ex_ready_out}, 64'd0);
        chk("rst result", ex_alu_result_out, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle ready", {63'd0, ex_ready_out}, 64'd1);

        // back-to-back single-cycle ops
        ex_ready_in = 1'b1;
        ex_valid_in = 1'b1;
        ex_alu_op_in = 4'd0; ex_operand1_in = 64'd5; ex_operand2_in = 64'd7;
        @(posedge clk); #1;
        chk("b2b add valid", {63'd0, ex_valid_out}, 64'd1);
        chk("b2b add", ex_alu_result_out, 64'd12);
        ex_alu_op_in = 4'd8; ex_operand1_in = ONES; ex_operand2_in = 64'd1;
        @(posedge clk); #1;
        chk("b2b slt valid", {63'd0, ex_valid_out}, 64'd1);
        chk("b2b slt", ex_alu_result_out, 64'd1);
        ex_alu_op_in = 4'd9;
        @(posedge clk); #1;
        chk("b2b sltu valid", {63'd0, ex_valid_out}, 64'd1);
        chk("b2b sltu", ex_alu_result_out, 64'd0);
        ex_valid_in = 1'b0;
        @(posedge clk); #1;
        chk("b2b idle", {63'd0, ex_valid_out}, 64'd0);

        // iterative and special-case directed vectors
        do_op("div -7/2", 4'd12, -64'sd7, 64'd2);
        do_op("rem -7/2", 4'd13, -64'sd7, 64'd2);
        do_op("divu 100/7", 4'd14, 64'd100, 64'd7);
        do_op("remu 100/7", 4'd15, 64'd100, 64'd7);
        do_op("div 9/0", 4'd12, 64'd9, 64'd0);
        do_op("rem 9/0", 4'd13, 64'd9, 64'd0);
        do_op("div min/-1", 4'd12, MIN, ONES);
        do_op("rem min/-1", 4'd13, MIN, ONES);
        do_op("mul 3*-4", 4'd10, 64'd3, -64'sd4);
        do_op("mulh -1*-1", 4'd11, ONES, ONES);
        do_op("mulh min*2", 4'd11, MIN, 64'd2);

        // backpressure
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        ex_ready_in = 1'b0;
        ex_alu_op_in = 4'd1; ex_operand1_in = ra; ex_operand2_in = rb;
        ex_valid_in = 1'b1;
        @(posedge clk); #1;
        ex_valid_in = 1'b0;
        held = ra - rb;
        chk("bp first valid", {63'd0, ex_valid_out}, 64'd1);
        chk("bp first result", ex_alu_result_out, held);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp hold valid", {63'd0, ex_valid_out}, 64'd1);
            chk("bp hold result", ex_alu_result_out, held);
            chk("bp hold ready", {63'd0, ex_ready_out}, 64'd0);
        end
        ex_ready_in = 1'b1;
        @(posedge clk); #1;
        chk("bp release valid", {63'd0, ex_valid_out}, 64'd0);
        chk("bp release ready", {63'd0, ex_ready_out}, 64'd1);

        // flush mid-divide
        ex_alu_op_in = 4'd12; ex_operand1_in = 64'd1000; ex_operand2_in = 64'd3;
        ex_valid_in = 1'b1;
        @(posedge clk); #1;
        ex_valid_in = 1'b0;
        repeat (19) @(posedge clk);
        #1 ex_flush_in = 1'b1;
        @(posedge clk); #1;
        ex_flush_in = 1'b0;
        chk("flush valid", {63'd0, ex_valid_out}, 64'd0);
        chk("flush ready", {63'd0, ex_ready_out}, 64'd1);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (ex_valid_out) seen++;
        end
        chk("flush no result", 64'(seen), 64'd0);
        do_op("post-flush add", 4'd0, 64'd1, 64'd1);

        // reset mid-multiply
        ex_alu_op_in = 4'd10; ex_operand1_in = 64'd12345; ex_operand2_in = 64'd678;
        ex_valid_in = 1'b1;
        @(posedge clk); #1;
        ex_valid_in = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst valid", {63'd0, ex_valid_out}, 64'd0);
        chk("midrst ready", {63'd0, ex_ready_out}, 64'd0);
        chk("midrst result", ex_alu_result_out, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst ready after", {63'd0, ex_ready_out}, 64'd1);
        chk("midrst valid after", {63'd0, ex_valid_out}, 64'd0);
        do_op("post-reset add", 4'd0, 64'd1, 64'd1);

        // randomized ops, biased toward the divide corner cases
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
                1: begin ra = 64'($signed(32'($urandom_range(0, 200)) - 32'sd100));
                         rb = 64'($signed(32'($urandom_range(0, 40)) - 32'sd20)); end
                2: begin ra = {$urandom, $urandom}; rb = 64'd0; end
                default: begin ra = MIN; rb = ONES; end
            endcase
            do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ex_seq_alu.md
Name: ex_seq_alu

Overview:
- Parametrised, multi-cycle execute-stage ALU, the successor to the single-cycle combinational ALU.
- Generalised to XLEN-bit operands, with correct signed/unsigned compares.
- Iterative MUL/MULH and DIV/REM (signed and unsigned) with RISC-V divide-by-zero and overflow semantics.
- Valid/ready handshakes on both sides and a flush input, so the EX stage can stall on long operations.

Parameters:
- XLEN, 64, operand/result width in bits (>=8, power of two).
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ex_flush_in  input  1  synchronous kill of in-flight operation
- ex_valid_in  input  1  request valid
- ex_ready_out  output  1  block can accept a request
- ex_operand1_in  input  XLEN  operand A (rs1)
- ex_operand2_in  input  XLEN  operand B (rs2/imm)
- ex_alu_op_in  input  4  operation, alu_op_e
- ex_valid_out  output  1  result valid
- ex_ready_in  input  1  consumer accepts result
- ex_alu_result_out  output  XLEN  result, registered

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: FSM=IDLE, ex_valid_out=0, ex_alu_result_out=0, counter=0. ex_ready_out is forced 0 while rst_n=0.
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount = operand2[$clog2(XLEN)-1:0])
  - 8 SLT (signed), 9 SLTU (unsigned, operand1 vs operand2)
  - 10 MUL (low XLEN bits), 11 MULH (signed x signed, high XLEN bits)
  - 12 DIV (signed), 13 REM (signed), 14 DIVU, 15 REMU
- FSM states: IDLE, BUSY, DONE.
- Accept: ex_valid_in & ex_ready_out. ex_ready_out = (IDLE) | (DONE & ex_ready_in), so back-to-back accept is possible while a result drains.
- Ops 0-9: IDLE->DONE. Result registered; ex_valid_out=1 on the cycle after accept (latency 1).
- MUL/MULH: operands latched as magnitudes plus sign flag. Shift-add, one bit per cycle, 2*XLEN accumulator.
  - BUSY for XLEN cycles, then DONE.
  - ex_valid_out at cycle XLEN+1 after accept.
  - Product is negated if the signs differ (signed MULH only; MUL low bits are sign-agnostic).
- DIV/REM/DIVU/REMU: restoring division, one quotient bit per cycle, XLEN cycles in BUSY, then DONE (latency XLEN+1).
  - Signed ops divide magnitudes, then fix signs: quotient negative iff signs differ; remainder takes the dividend's sign.
- Divide special cases (detected at accept, skip BUSY, latency 1):
  - divisor=0: quotient = all ones, remainder = dividend.
  - Signed MIN / -1: quotient = MIN, remainder = 0.
- DONE: ex_valid_out=1 and ex_alu_result_out stable until ex_ready_in=1.
  - On ex_ready_in with no new accept -> IDLE, ex_valid_out=0.
  - With a simultaneous accept, the new request proceeds as if from IDLE.
- BUSY: ex_ready_out=0. Input changes are ignored (operands latched at accept).
- ex_flush_in=1: next state IDLE, ex_valid_out=0, counter cleared. Flush has priority over accept and completion in the same cycle; the result register may hold stale data.
- Reset asserted mid-operation: immediate return to reset state. No partial result is ever presented.
- Ops are accepted only when ex_valid_in=1. Unused op encodings do not exist (all 16 are defined).

Decomposition:
- Package alu_pkg:
  - alu_op_e (4-bit enum, codes above)
  - alu_state_e (IDLE/BUSY/DONE)
  - helper function is_iterative(op)
- Sub-module ex_muldiv_iter:
  - Holds the shift-add/restoring datapath and the counter.
  - Interface: start, op, a, b in; done, result out.
  - Top handles the FSM, handshakes, single-cycle ops and special-case bypass.

Test Plan:
- XLEN=64. ADD 5+7, then SLT -1 vs 1, then SLTU -1 vs 1, each accepted back-to-back with ex_ready_in=1 -> results 12, 1, 0 on consecutive cycles, each 1 cycle after its accept.
- DIV -7/2 and REM -7/2 -> -3 and -1, ex_valid_out rising exactly 65 cycles after accept. DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 9/0 -> 0xFFFF_FFFF_FFFF_FFFF; REM 9/0 -> 9; DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000 and REM -> 0, each with latency 1.
- MUL 3*-4 -> -12; MULH -1*-1 -> 0; MULH 0x8000_0000_0000_0000 * 2 -> 0xFFFF_FFFF_FFFF_FFFF, each with latency 65.
- Backpressure: hold ex_ready_in=0 for 10 cycles after a result -> ex_valid_out and result stable, ex_ready_out=0; release -> one transfer, then IDLE.
- Flush at cycle 20 of a DIV, and separately rst_n pulsed low mid-MUL -> ex_valid_out stays 0, ex_ready_out=1 next cycle, and a following ADD 1+1 returns 2.
